// File: rtl/ph_ram.sv
// Byte-addressed RAM with little-endian multi-lane access, address wrap and a
// LATENCY-deep read return pipeline (read-first on simultaneous read/write).
module ph_ram #(
   parameter int    DATA_W    = 32,
   parameter int    ADDR_W    = 16,
   parameter int    LATENCY   = 1,
   parameter string INIT_FILE = ""
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                readReq,
   input  logic                writeReq,
   input  logic [31:0]         address,
   input  logic [DATA_W-1:0]   writeData,
   input  logic [DATA_W/8-1:0] byteEn,
   output logic [DATA_W-1:0]   readData,
   output logic                readValid,
   output logic                addrErr,
   output logic [2:0]          pending
);

   localparam int LANES = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] lane_addr [LANES];
   logic [DATA_W-1:0] rd_word;
   logic              in_range;
   logic              rd_acc;
   logic              wr_acc;

   logic [LATENCY-1:0] vld_q, vld_d;
   logic [DATA_W-1:0]  dat_q [LATENCY];
   logic [DATA_W-1:0]  dat_d [LATENCY];
   logic               err_q, err_d;
   logic [2:0]         pending_q, pending_d;

   always_comb begin
      in_range = ((address >> ADDR_W) == 32'd0);
      rd_acc   = readReq & in_range;
      wr_acc   = writeReq & in_range;
      rd_word  = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_addr[i]     = address[ADDR_W-1:0] + ADDR_W'(i);
         rd_word[8*i +: 8] = mem[lane_addr[i]];
      end
   end

   // A stage only takes new data when a valid enters it, so the last stage
   // naturally holds readData between strobes.
   always_comb begin
      vld_d    = '0;
      vld_d[0] = rd_acc;
      dat_d[0] = rd_acc ? rd_word : dat_q[0];
      for (int k = 1; k < LATENCY; k++) begin
         vld_d[k] = vld_q[k-1];
         dat_d[k] = vld_q[k-1] ? dat_q[k-1] : dat_q[k];
      end
      err_d     = (readReq | writeReq) & ~in_range;
      pending_d = pending_q + {2'b00, vld_d[0]} - {2'b00, vld_q[LATENCY-1]};
   end

   // Storage shares the reset process only so that writes are ignored while
   // reset is low; its contents are never cleared.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_q     <= '0;
         err_q     <= 1'b0;
         pending_q <= 3'd0;
         for (int k = 0; k < LATENCY; k++) dat_q[k] <= '0;
      end else begin
         vld_q     <= vld_d;
         err_q     <= err_d;
         pending_q <= pending_d;
         for (int k = 0; k < LATENCY; k++) dat_q[k] <= dat_d[k];
         for (int i = 0; i < LANES; i++) begin
            if (wr_acc && byteEn[i]) mem[lane_addr[i]] <= writeData[8*i +: 8];
         end
      end
   end

   assign readValid = vld_q[LATENCY-1];
   assign readData  = dat_q[LATENCY-1];
   assign addrErr   = err_q;
   assign pending   = pending_q;

endmodule

// File: tb/tb_ph_ram.sv
// Self-checking bench for ph_ram: three instances (LATENCY 1, 3, 2) share the
// request bus; a per-instance scoreboard checks data, return cycle and pending.
module tb_ph_ram;

   logic        clk = 1'b0;
   logic        rst_a, rst_b;
   logic        rd, wr;
   logic [31:0] addr, wd;
   logic [3:0]  be;

   logic        rv   [3];
   logic [31:0] rdat [3];
   logic        err  [3];
   logic [2:0]  pend [3];

   int lat [3] = '{1, 3, 2};

   typedef struct {
      logic [31:0] d;
      int          due;
   } exp_t;
   exp_t sbq [3][$];

   typedef struct {
      logic        r;
      logic        w;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [31:0] ed;
      logic        ee;
   } vec_t;
   vec_t tbl [17];

   logic [7:0]  mdl [65536];
   logic [31:0] last [3];
   int          maxp [3];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ph_ram u_l1 (
      .clk(clk), .reset(rst_a), .readReq(rd), .writeReq(wr), .address(addr),
      .writeData(wd), .byteEn(be), .readData(rdat[0]), .readValid(rv[0]),
      .addrErr(err[0]), .pending(pend[0]));

   ph_ram #(.LATENCY(3)) u_l3 (
      .clk(clk), .reset(rst_a), .readReq(rd), .writeReq(wr), .address(addr),
      .writeData(wd), .byteEn(be), .readData(rdat[1]), .readValid(rv[1]),
      .addrErr(err[1]), .pending(pend[1]));

   ph_ram #(.LATENCY(2)) u_l2 (
      .clk(clk), .reset(rst_b), .readReq(rd), .writeReq(wr), .address(addr),
      .writeData(wd), .byteEn(be), .readData(rdat[2]), .readValid(rv[2]),
      .addrErr(err[2]), .pending(pend[2]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic dut_live(input int k);
      return (k == 2) ? rst_b : rst_a;
   endfunction

   task automatic mon(input int k);
      int   cnt = 0;
      exp_t e;
      for (int j = 0; j < sbq[k].size(); j++)
         if (sbq[k][j].due - lat[k] + 1 <= cyc) cnt++;
      chk($sformatf("pending_u%0d", k), {29'd0, pend[k]}, cnt);
      if (int'(pend[k]) > maxp[k]) maxp[k] = int'(pend[k]);
      if (rv[k]) begin
         if (sbq[k].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_valid_u%0d actual=1 expected=0 t=%0t", k, $time);
         end else begin
            e = sbq[k].pop_front();
            chk($sformatf("rdata_u%0d", k), rdat[k], e.d);
            chk($sformatf("rcycle_u%0d", k), cyc, e.due);
            last[k] = e.d;
         end
      end else begin
         chk($sformatf("hold_u%0d", k), rdat[k], last[k]);
      end
   endtask

   always @(negedge clk) for (int k = 0; k < 3; k++) mon(k);

   task automatic step(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       input logic use_tbl, input logic [31:0] ted, input logic ee);
      logic [31:0] word;
      logic        inr;
      logic        b_live;
      inr    = (a[31:16] == 16'd0);
      b_live = rst_b;
      for (int i = 0; i < 4; i++) word[8*i +: 8] = mdl[16'(a[15:0] + 16'(i))];
      if (use_tbl) word = ted;
      rd = r; wr = w; addr = a; wd = d; be = b;
      if (r && inr)
         for (int k = 0; k < 3; k++)
            if (dut_live(k)) sbq[k].push_back('{word, cyc + lat[k]});
      if (w && inr && rst_a)
         for (int i = 0; i < 4; i++)
            if (b[i]) mdl[16'(a[15:0] + 16'(i))] = d[8*i +: 8];
      @(negedge clk);
      chk("addr_err", {30'd0, err[1], err[0]}, {30'd0, ee, ee});
      if (b_live) chk("addr_err_u2", {31'd0, err[2]}, {31'd0, ee});
   endtask

   task automatic drain();
      rd = 1'b0; wr = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (sbq[0].size() + sbq[1].size() + sbq[2].size() == 0) break;
         @(negedge clk);
      end
      chk("drain", sbq[0].size() + sbq[1].size() + sbq[2].size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        r, w, ee;
      logic [31:0] a;

      rst_a = 1'b0; rst_b = 1'b0;
      rd = 1'b0; wr = 1'b0; addr = '0; wd = '0; be = '0;
      for (int i = 0; i < 65536; i++) mdl[i] = 8'h00;
      for (int k = 0; k < 3; k++) begin last[k] = '0; maxp[k] = 0; end

      tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0,         1'b0};
      tbl[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 32'h0000_0011, 32'h0,         4'b0000, 32'h00DE_ADBE, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hAAAA_AAAA, 4'b1111, 32'h0,         1'b0};
      tbl[4]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'b0101, 32'h0,         1'b0};
      tbl[5]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         4'b0000, 32'hAA22_AA44, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 32'h0000_FFFE, 32'h0102_0304, 4'b1111, 32'h0,         1'b0};
      tbl[7]  = '{1'b1, 1'b0, 32'h0000_FFFE, 32'h0,         4'b0000, 32'h0102_0304, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 32'h0000_FFFF, 32'h0,         4'b0000, 32'h0001_0203, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'h0000_0102, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 32'h0001_0000, 32'hFFFF_FFFF, 4'b1111, 32'h0,         1'b1};
      tbl[11] = '{1'b1, 1'b0, 32'h0001_0000, 32'h0,         4'b0000, 32'h0,         1'b1};
      tbl[12] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'h0000_0102, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0005, 4'b1111, 32'h0,         1'b0};
      tbl[14] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0000_0009, 4'b1111, 32'h0000_0005, 1'b0};
      tbl[15] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         4'b0000, 32'h0000_0009, 1'b0};
      tbl[16] = '{1'b1, 1'b1, 32'h8000_0004, 32'h1234_5678, 4'b1111, 32'h0,         1'b1};

      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_valid_u%0d", k), {31'd0, rv[k]}, 32'd0);
         chk($sformatf("rst_err_u%0d", k), {31'd0, err[k]}, 32'd0);
         chk($sformatf("rst_rdata_u%0d", k), rdat[k], 32'd0);
      end
      rst_a = 1'b1; rst_b = 1'b1;

      for (int i = 0; i < 'h80; i += 4) step(1'b0, 1'b1, i, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b1, 32'h0000_FFFC, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0);

      for (int i = 0; i < 17; i++)
         step(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].be, 1'b1, tbl[i].ed, tbl[i].ee);
      drain();

      for (int k = 0; k < 3; k++) maxp[k] = 0;
      step(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
      drain();
      chk("l3_pending_peak", maxp[1], 3);
      chk("l3_pending_end", {29'd0, pend[1]}, 32'd0);

      for (int n = 0; n < 60; n++) begin
         r = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         a = $urandom_range(0, 'h7C);
         if ($urandom_range(0, 7) == 0) a = a | (32'h0001_0000 << $urandom_range(0, 15));
         ee = (r | w) & (a[31:16] != 16'd0);
         step(r, w, a, $urandom, 4'($urandom_range(0, 15)), 1'b0, 32'h0, ee);
      end
      drain();
      chk("max_pending_l1", {31'd0, (maxp[0] <= 1)}, 32'd1);
      chk("max_pending_l3", {31'd0, (maxp[1] <= 3)}, 32'd1);
      chk("max_pending_l2", {31'd0, (maxp[2] <= 2)}, 32'd1);

      step(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
      #2;
      rst_b = 1'b0;
      sbq[2].delete();
      last[2] = '0;
      #1;
      chk("rst_async_valid", {31'd0, rv[2]}, 32'd0);
      chk("rst_async_pending", {29'd0, pend[2]}, 32'd0);
      chk("rst_async_rdata", rdat[2], 32'd0);
      rd = 1'b0;
      @(negedge clk);
      step(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
      rd = 1'b0;
      repeat (4) @(negedge clk);
      rst_b = 1'b1;
      step(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0000_FFFE, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
      drain();
      chk("final_pending_u2", {29'd0, pend[2]}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ph_ram.md
PH_RAM -- requirements
Module: ph_ram

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data bus width in bits; legal values are multiples of 8 in the range 8..128.
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning the byte-address width of storage; storage depth is 2**ADDR_W bytes.
REQ-003 The block SHALL have parameter LATENCY, default 1, meaning the read latency in cycles; legal values are 1..4.
REQ-004 The block SHALL have parameter INIT_FILE, default "", meaning a hex byte image loaded at elaboration; an empty string leaves the contents unloaded.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port readReq, input, 1 bit: read request, sampled every rising edge.
REQ-008 Port writeReq, input, 1 bit: write request, sampled every rising edge.
REQ-009 Port address, input, 32 bits: byte address of the lowest byte of the access.
REQ-010 Port writeData, input, DATA_W bits: write data, little-endian (bits [7:0] go to the byte at address).
REQ-011 Port byteEn, input, DATA_W/8 bits: write lane enables; lane i covers writeData[8i+7:8i].
REQ-012 Port readData, output, DATA_W bits: read result, little-endian.
REQ-013 Port readValid, output, 1 bit: one-cycle strobe marking readData valid.
REQ-014 Port addrErr, output, 1 bit: one-cycle strobe flagging an out-of-range request.
REQ-015 Port pending, output, 3 bits: count of reads accepted but not yet returned.

Function
REQ-016 A byte address is in range when address[31:ADDR_W] == 0; every byte lane uses address+i modulo 2**ADDR_W, so an access wraps from byte 2**ADDR_W-1 to byte 0.
REQ-017 Any request with an out-of-range address SHALL assert addrErr on the next cycle, perform no storage write, and return no read data.
REQ-018 A write SHALL update exactly the lanes whose byteEn bit is 1; lanes with byteEn 0 keep their previous contents.
REQ-019 A read accepted at edge N SHALL present readData together with readValid=1 for exactly one cycle, starting after edge N+LATENCY-1 (LATENCY=1: valid in the cycle after edge N).
REQ-020 The block SHALL accept one request per cycle, fully pipelined, with no stall; read results return in request order.
REQ-021 readData SHALL hold its last value while readValid=0.
REQ-022 When readReq and writeReq are both 1 in the same cycle, the read SHALL return the pre-write contents (read-first), and the write SHALL complete in that cycle.
REQ-023 A read accepted on the edge after a write SHALL return the newly written data, with no hazard window.
REQ-024 pending SHALL increment on each accepted in-range read, decrement on each readValid strobe, and remain unchanged when both occur in the same cycle; it never exceeds LATENCY.
REQ-025 The read pipeline SHALL be implemented as a LATENCY-deep shift of valid/data stages; no state machine beyond the stage valids is required.

Reset
REQ-026 Asserting reset (low) SHALL immediately clear readValid, addrErr, pending and all pipeline stage valids to 0, and set readData to 0.
REQ-027 A read in flight when reset is asserted SHALL be discarded and never produce readValid.
REQ-028 Reset SHALL NOT clear storage contents; INIT_FILE contents persist across reset.
REQ-029 readReq and writeReq SHALL be ignored while reset is low; requests are accepted from the first rising edge after reset deasserts.

Verification
REQ-030 Defaults: write 0xDEADBEEF at address 0x10 with byteEn=4'b1111, then read 0x10 -> readValid after 1 cycle with readData=0xDEADBEEF; a read of 0x11 -> 0x00DEADBE (byte 0x14 unwritten, 0).
REQ-031 Byte enables: write 0x11223344 at 0x20 with byteEn=4'b0101 over prior contents 0xAAAAAAAA -> read returns 0xAA22AA44.
REQ-032 Wrap and error: write 0x01020304 at 0xFFFE -> bytes 0xFFFE=0x04, 0xFFFF=0x03, 0x0000=0x02, 0x0001=0x01; request at 0x00010000 -> addrErr pulse, storage unchanged, no readValid.
REQ-033 LATENCY=3, back-to-back reads of 0x0, 0x4, 0x8 on consecutive edges -> three consecutive readValid cycles in order; pending peaks at 3 and returns to 0.
REQ-034 Simultaneous read and write of 0x40 (old 0x5, new 0x9) -> returns 0x5; a read on the next edge returns 0x9.
REQ-035 LATENCY=2, assert reset one cycle after a read -> no readValid ever appears for that read, pending=0, readData=0, and memory contents are preserved after reset deasserts.
